// File: rtl/tdm_demux_1_to_2.sv
// tdm_demux_1_to_2
//   Splits a serial, MSB-first, time-multiplexed bit stream into two
//   DATA_W-bit channel words. A frame is DATA_W bits of channel 0 followed
//   immediately by DATA_W bits of channel 1. i_sync marks the first bit of
//   every frame.
//
// Ports
//   i_clk       rising-edge clock
//   i_rst_n     asynchronous active-low reset
//   i_en        block disable (1 = held idle, 0 = running)
//   i_sync      frame marker, high on channel-0 MSB
//   i_data      serial data, one bit per clock
//   o_data_0    last complete channel-0 word
//   o_data_1    last complete channel-1 word
//   o_valid_0   one-cycle pulse when o_data_0 updates
//   o_valid_1   one-cycle pulse when o_data_1 updates
//   o_sync_err  one-cycle pulse on a framing error
//   o_busy      high while the deframer is not idle
module tdm_demux_1_to_2 #(
  parameter int DATA_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_en,
  input  logic              i_sync,
  input  logic              i_data,
  output logic [DATA_W-1:0] o_data_0,
  output logic [DATA_W-1:0] o_data_1,
  output logic              o_valid_0,
  output logic              o_valid_1,
  output logic              o_sync_err,
  output logic              o_busy
);

  localparam int CW = (DATA_W > 2) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DATA_W - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE,
    SLOT0,
    SLOT1
  } state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] shift;
  logic [DATA_W-1:0] shift_in;
  logic              frame_start;

  assign shift_in    = {shift[DATA_W-2:0], i_data};
  // Bit 0 of SLOT0 is only reached after a completed frame and must carry sync.
  assign frame_start = (state == SLOT0) && (cnt == '0);
  assign o_busy      = (state != IDLE);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      shift      <= '0;
      o_data_0   <= '0;
      o_data_1   <= '0;
      o_valid_0  <= 1'b0;
      o_valid_1  <= 1'b0;
      o_sync_err <= 1'b0;
    end else begin
      o_valid_0  <= 1'b0;
      o_valid_1  <= 1'b0;
      o_sync_err <= 1'b0;
      if (i_en) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (i_sync) begin
              shift <= shift_in;
              cnt   <= CNT_ONE;
              state <= SLOT0;
            end
          end
          default: begin
            if (frame_start) begin
              if (i_sync) begin
                shift <= shift_in;
                cnt   <= CNT_ONE;
              end else begin
                o_sync_err <= 1'b1;
                state      <= IDLE;
                cnt        <= '0;
              end
            end else if (i_sync) begin
              // Misplaced sync beats word completion: restart on this bit.
              o_sync_err <= 1'b1;
              shift      <= shift_in;
              cnt        <= CNT_ONE;
              state      <= SLOT0;
            end else begin
              shift <= shift_in;
              if (cnt == CNT_LAST) begin
                cnt <= '0;
                if (state == SLOT0) begin
                  o_data_0  <= shift_in;
                  o_valid_0 <= 1'b1;
                  state     <= SLOT1;
                end else begin
                  o_data_1  <= shift_in;
                  o_valid_1 <= 1'b1;
                  state     <= SLOT0;
                end
              end else begin
                cnt <= cnt + CNT_ONE;
              end
            end
          end
        endcase
      end
    end
  end

endmodule
